// File: rtl/mont_mul_if.sv
// ----------------------------------------------------------------------------
// mont_mul_if
// Start/done handshake and operand bus of the bit-serial Montgomery multiplier.
//
// Signals:
//   in_sig  : start request (master -> slave), sampled only while idle
//   A_i     : multiplicand, Montgomery form (master -> slave)
//   B_i     : multiplier, Montgomery form (master -> slave)
//   Prime   : odd modulus (master -> slave)
//   Result  : A*B*2^-WIDTH mod Prime, fully reduced (slave -> master)
//   done    : one-cycle pulse, Result valid (slave -> master)
//   busy    : multiplier not idle (slave -> master)
//
// Modports:
//   master : the requester driving operands and start
//   slave  : the multiplier
// ----------------------------------------------------------------------------
interface mont_mul_if #(
    parameter int WIDTH = 32
);
    logic             in_sig;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic [WIDTH-1:0] Prime;
    logic [WIDTH-1:0] Result;
    logic             done;
    logic             busy;

    modport master (
        output in_sig,
        output A_i,
        output B_i,
        output Prime,
        input  Result,
        input  done,
        input  busy
    );

    modport slave (
        input  in_sig,
        input  A_i,
        input  B_i,
        input  Prime,
        output Result,
        output done,
        output busy
    );
endinterface : mont_mul_if

// File: rtl/mont_mul.sv
// ----------------------------------------------------------------------------
// mont_mul
// Bit-serial radix-2 Montgomery multiplier:
//     Result = A * B * 2^-WIDTH mod Prime
// Consumes Montgomery-domain coordinates in the ECC point-arithmetic datapath.
// One multiplication: 1 load cycle, WIDTH iteration cycles, 1 final-reduction
// cycle and 1 output cycle in which done is high.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : mont_mul_if slave modport
//            in_sig (start), A_i, B_i, Prime (operands, sampled on the start
//            edge only), Result (held until the next final reduction),
//            done (one-cycle pulse), busy (not idle)
//
// Operands are expected < 2*Prime and Prime odd, 3 <= Prime < 2^WIDTH;
// anything else gives an undefined Result and is not detected.
// ----------------------------------------------------------------------------
module mont_mul #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    mont_mul_if.slave    bus
);

    localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Single conditional subtract bringing an operand < 2*m into [0, m).
    function automatic logic [WIDTH-1:0] cond_sub_w(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH-1:0] r;
        if (x >= m) begin
            r = x - m;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Same reduction on the WIDTH+1 bit accumulator (S < 2*m).
    function automatic logic [WIDTH:0] cond_sub_s(
        input logic [WIDTH:0]   x,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] r;
        if (x >= {1'b0, m}) begin
            r = x - {1'b0, m};
        end else begin
            r = x;
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [WIDTH-1:0]  a_q,     a_d;
    logic [WIDTH-1:0]  b_q,     b_d;
    logic [WIDTH-1:0]  p_q,     p_d;
    logic [WIDTH:0]    s_q,     s_d;
    logic [WIDTH-1:0]  result_q, result_d;

    // Iteration datapath. T needs WIDTH+2 bits: S < 2P, B < P, and the
    // optional +P for odd T gives T < 4P, which can set bit WIDTH+1.
    logic [WIDTH+1:0]  t_sum_s;
    logic [WIDTH+1:0]  t_red_s;
    logic [WIDTH:0]    s_next_s;
    logic [WIDTH:0]    s_fix_s;

    // One Montgomery iteration on the current multiplicand bit.
    always_comb begin
        t_sum_s = {1'b0, s_q};
        if (a_q[cnt_q]) begin
            t_sum_s = {1'b0, s_q} + {2'b00, b_q};
        end else begin
            t_sum_s = {1'b0, s_q};
        end

        // Adding the odd modulus makes T even so the shift is exact.
        if (t_sum_s[0]) begin
            t_red_s = t_sum_s + {2'b00, p_q};
        end else begin
            t_red_s = t_sum_s;
        end

        s_next_s = t_red_s[WIDTH+1:1];
        s_fix_s  = cond_sub_s(s_q, p_q);
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        s_d      = s_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (bus.in_sig) begin
                    // Operands may be up to 2*Prime; one subtract suffices.
                    a_d     = cond_sub_w(bus.A_i, bus.Prime);
                    b_d     = cond_sub_w(bus.B_i, bus.Prime);
                    p_d     = bus.Prime;
                    s_d     = {(WIDTH+1){1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end

            MUL: begin
                s_d = s_next_s;
                if (cnt_q == LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = FIX;
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = MUL;
                end
            end

            FIX: begin
                // S < 2P here, so one subtract gives the fully reduced value.
                result_d = s_fix_s[WIDTH-1:0];
                state_d  = OUT;
            end

            OUT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            p_q      <= {WIDTH{1'b0}};
            s_q      <= {(WIDTH+1){1'b0}};
            result_q <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            s_q      <= s_d;
            result_q <= result_d;
        end
    end

    // done and busy decode the state register only; no path from in_sig.
    assign bus.Result = result_q;
    assign bus.done   = (state_q == OUT);
    assign bus.busy   = (state_q != IDLE);

endmodule : mont_mul

// File: tb/tb_mont_mul.sv
// ----------------------------------------------------------------------------
// tb_mont_mul
// Directed and randomised stimulus for mont_mul. Each started operation pushes
// its expected Result and start edge onto a scoreboard queue; every done pulse
// pops one entry and compares Result and latency.
// ----------------------------------------------------------------------------
module tb_mont_mul;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic [31:0]  start;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mont_mul_if #(.WIDTH(W)) bus ();

    mont_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int unsigned cyc      = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;

    // Reference: full product reduced mod p, then divided by 2^W mod p by
    // W exact halvings.
    function automatic logic [W-1:0] model(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [W-1:0] p
    );
        logic [63:0] x;
        x = ((64'(a) % 64'(p)) * (64'(b) % 64'(p))) % 64'(p);
        for (int i = 0; i < W; i++) begin
            if (x[0]) x = x + 64'(p);
            x = x >> 1;
        end
        return x[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; cyc then equals the number of rising
    // edges seen. Consume a scoreboard entry on every done pulse.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result", 64'(bus.Result), 64'(e.res));
                check("latency", 64'(cyc - e.start), 64'd33);
            end
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] p, input logic [W-1:0] e,
                            input bit push);
        bus.A_i    = a;
        bus.B_i    = b;
        bus.Prime  = p;
        bus.in_sig = 1'b1;
        if (push) sb.push_back('{res: e, start: cyc + 1});
        busy_cnt = 0;
        done_cnt = 0;
        tick();
        bus.in_sig = 1'b0;
    endtask

    // One operation; operands and in_sig are scrambled while it is in flight.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] p, input logic [W-1:0] e,
                          input string tag);
        start_op(a, b, p, e, 1'b1);
        for (int i = 0; i < 33; i++) begin
            bus.A_i    = $urandom;
            bus.B_i    = $urandom;
            bus.Prime  = $urandom;
            bus.in_sig = 1'($urandom_range(0, 1));
            tick();
        end
        bus.in_sig = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd34);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [W-1:0] p;
        logic [W-1:0] x;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   sum;

        reset      = 1'b0;
        bus.in_sig = 1'b0;
        bus.A_i    = '0;
        bus.B_i    = '0;
        bus.Prime  = '0;
        tick();
        tick();
        check("reset_result", 64'(bus.Result), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        reset = 1'b1;
        tick();

        // Small modulus, directed values.
        run_op(32'd6,  32'd1,  32'd13, 32'd5, "p13_6x1");
        run_op(32'd12, 32'd12, 32'd13, 32'd3, "p13_12x12");
        run_op(32'd20, 32'd1,  32'd13, 32'd8, "p13_input_reduce");

        // Modulus near 2^W, including maximal operands.
        run_op(32'd1, 32'd1, 32'hFFFF_FFFB, 32'hCCCC_CCC9, "pbig_1x1");
        run_op(32'd5, 32'd5, 32'hFFFF_FFFB, 32'd5, "pbig_5x5");
        run_op(32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'hCCCC_CCC9, "pbig_max");

        // Zero operands.
        run_op(32'd0, 32'd7, 32'd13, 32'd0, "zero_a");
        run_op(32'd7, 32'd0, 32'd13, 32'd0, "zero_b");

        // Random odd moduli with operands up to 2*p.
        for (int k = 0; k < 4; k++) begin
            p = $urandom | 32'd1;
            if (p < 32'd3) p = 32'd3;
            x = $urandom % p;
            sum = {1'b0, x} + {1'b0, p};
            a = (sum[W] == 1'b0 && $urandom_range(0, 1) == 1) ? sum[W-1:0] : x;
            b = $urandom % p;
            run_op(a, b, p, model(a, b, p), "random");
        end

        // in_sig held high: back-to-back operations every 35 cycles.
        bus.A_i    = 32'd9;
        bus.B_i    = 32'd4;
        bus.Prime  = 32'd13;
        bus.in_sig = 1'b1;
        sb.push_back('{res: model(32'd9, 32'd4, 32'd13), start: cyc + 1});
        sb.push_back('{res: model(32'd9, 32'd4, 32'd13), start: cyc + 36});
        sb.push_back('{res: model(32'd9, 32'd4, 32'd13), start: cyc + 71});
        busy_cnt = 0;
        done_cnt = 0;
        repeat (100) tick();
        bus.in_sig = 1'b0;
        repeat (60) tick();
        check("held_done_pulses", 64'(done_cnt), 64'd3);
        check("held_busy_cycles", 64'(busy_cnt), 64'd102);
        check("held_result_value", 64'(bus.Result), 64'd4);

        // Reset asserted with the iteration counter at 10.
        start_op(32'd11, 32'd5, 32'd13, 32'd0, 1'b0);
        repeat (10) tick();
        #1 reset = 1'b0;
        #1;
        check("midreset_result", 64'(bus.Result), 64'd0);
        check("midreset_busy", 64'(bus.busy), 64'd0);
        check("midreset_done", 64'(bus.done), 64'd0);
        repeat (3) tick();
        reset    = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        repeat (40) tick();
        check("postreset_done_pulses", 64'(done_cnt), 64'd0);
        check("postreset_busy_cycles", 64'(busy_cnt), 64'd0);

        // Fresh operation after reset.
        run_op(32'd3, 32'd5, 32'd7, 32'd2, "p7_after_reset");

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mont_mul
